// File: rtl/systema_cpu_debug_jtag_pkg.sv
// rtl/systema_cpu_debug_jtag_pkg.sv - shared types and constants for the virtual-JTAG debug host
// Purpose: FSM state encoding, default scan-chain widths and named virtual IR codes.
package systema_cpu_debug_jtag_pkg;

  localparam int DR_LEN_DEF = 38;
  localparam int IR_LEN_DEF = 2;

  localparam logic [1:0] IR_OCIMEM   = 2'b00;
  localparam logic [1:0] IR_TRACE    = 2'b01;
  localparam logic [1:0] IR_BREAK    = 2'b10;
  localparam logic [1:0] IR_TRACEMEM = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/systema_cpu_debug_jtag_tckgen.sv
// rtl/systema_cpu_debug_jtag_tckgen.sv - scan clock generator with edge pulses
// Purpose: divides clk into a TCK of 2*TCK_HALF clk cycles, low half first.
// Ports:
//   clk_i, reset_n_i  system clock, synchronous active-low reset
//   en_i              run TCK; when low, TCK and the half-period counter are held at 0
//   tck_o             generated scan clock
//   tck_rise_o        one-clk pulse: tck_o goes 0->1 at the next clk edge
//   tck_fall_o        one-clk pulse: tck_o goes 1->0 at the next clk edge
module systema_cpu_debug_jtag_tckgen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  output logic tck_o,
  output logic tck_rise_o,
  output logic tck_fall_o
);

  localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TCK_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          wrap;

  assign wrap = en_i && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en_i) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o      = tck_q;
  assign tck_rise_o = wrap && !tck_q;
  assign tck_fall_o = wrap && tck_q;

endmodule

// File: rtl/systema_cpu_debug_jtag_host.sv
// rtl/systema_cpu_debug_jtag_host.sv - virtual-JTAG initiator for the CPU debug slave
// Purpose: turns one parallel command (IR + DR) into a UIR/CDR/SDR/UDR scan and
//          returns the DR bits shifted out of the slave.
// Ports:
//   clk_i, reset_n_i                 system clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o          command handshake; cmd_ir_i, cmd_data_i (LSB shifted first)
//   rsp_valid_o/rsp_ready_i          response handshake; rsp_data_o, rsp_ir_out_o
//   vji_tck_o, vji_tdi_o, vji_tdo_i  scan clock and serial data
//   vji_ir_in_o, vji_ir_out_i        virtual IR value and slave status
//   vji_uir/cdr/sdr/udr_o, vji_rti_o virtual-state strobes and idle indication
module systema_cpu_debug_jtag_host import systema_cpu_debug_jtag_pkg::*; #(
  parameter int DR_LEN   = DR_LEN_DEF,
  parameter int IR_LEN   = IR_LEN_DEF,
  parameter int TCK_HALF = 2
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [IR_LEN-1:0] cmd_ir_i,
  input  logic [DR_LEN-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DR_LEN-1:0] rsp_data_o,
  output logic [IR_LEN-1:0] rsp_ir_out_o,
  output logic              vji_tck_o,
  output logic              vji_tdi_o,
  input  logic              vji_tdo_i,
  output logic [IR_LEN-1:0] vji_ir_in_o,
  input  logic [IR_LEN-1:0] vji_ir_out_i,
  output logic              vji_uir_o,
  output logic              vji_cdr_o,
  output logic              vji_sdr_o,
  output logic              vji_udr_o,
  output logic              vji_rti_o
);

  localparam int BW = (DR_LEN > 1) ? $clog2(DR_LEN) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_LEN - 1);

  state_e            state_q;
  logic [DR_LEN-1:0] sr_q;
  logic [BW-1:0]     bit_q;
  logic              tdi_q;
  logic [IR_LEN-1:0] ir_in_q;
  logic              uir_q, cdr_q, sdr_q, udr_q, rti_q;
  logic              cmd_ready_q, rsp_valid_q;
  logic [DR_LEN-1:0] rsp_data_q;
  logic [IR_LEN-1:0] rsp_ir_out_q;

  logic tck_en, tck_rise, tck_fall;

  assign tck_en = (state_q != ST_IDLE) && (state_q != ST_RESP);

  systema_cpu_debug_jtag_tckgen #(.TCK_HALF(TCK_HALF)) u_tckgen (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .en_i       (tck_en),
    .tck_o      (vji_tck_o),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall)
  );

  // Every phase ends on a TCK falling edge, so each strobe covers whole TCK cycles.
  // tdi has its own register: sr shifts on the rising edge, but tdi may only
  // move on the falling edge.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      bit_q        <= '0;
      tdi_q        <= 1'b0;
      ir_in_q      <= '0;
      uir_q        <= 1'b0;
      cdr_q        <= 1'b0;
      sdr_q        <= 1'b0;
      udr_q        <= 1'b0;
      rti_q        <= 1'b1;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ir_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            ir_in_q     <= cmd_ir_i;
            sr_q        <= cmd_data_i;
            cmd_ready_q <= 1'b0;
            rti_q       <= 1'b0;
            uir_q       <= 1'b1;
            state_q     <= ST_UIR;
          end
        end
        ST_UIR: begin
          if (tck_rise) rsp_ir_out_q <= vji_ir_out_i;
          if (tck_fall) begin
            uir_q   <= 1'b0;
            cdr_q   <= 1'b1;
            state_q <= ST_CDR;
          end
        end
        ST_CDR: begin
          if (tck_fall) begin
            cdr_q   <= 1'b0;
            sdr_q   <= 1'b1;
            bit_q   <= '0;
            tdi_q   <= sr_q[0];
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tck_rise) sr_q <= {vji_tdo_i, sr_q[DR_LEN-1:1]};
          if (tck_fall) begin
            if (bit_q == BIT_LAST) begin
              sdr_q   <= 1'b0;
              udr_q   <= 1'b1;
              tdi_q   <= 1'b0;
              state_q <= ST_UDR;
            end else begin
              bit_q <= bit_q + 1'b1;
              tdi_q <= sr_q[0];
            end
          end
        end
        ST_UDR: begin
          if (tck_fall) begin
            udr_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= sr_q;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            rti_q       <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_ir_out_o = rsp_ir_out_q;
  assign vji_tdi_o    = tdi_q;
  assign vji_ir_in_o  = ir_in_q;
  assign vji_uir_o    = uir_q;
  assign vji_cdr_o    = cdr_q;
  assign vji_sdr_o    = sdr_q;
  assign vji_udr_o    = udr_q;
  assign vji_rti_o    = rti_q;

endmodule

// File: tb/tb_systema_cpu_debug_jtag_host.sv
// tb/tb_systema_cpu_debug_jtag_host.sv - self-checking bench for the virtual-JTAG debug host
module tb_systema_cpu_debug_jtag_host;
  import systema_cpu_debug_jtag_pkg::*;

  localparam int DR  = 38;
  localparam int IRW = 2;
  localparam int TH  = 2;
  localparam int LAT = (DR + 3) * 2 * TH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic           vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [IRW-1:0] cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
  logic [DR-1:0]  cmd_data, rsp_data;

  logic           b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready;
  logic           b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti;
  logic [IRW-1:0] b_cmd_ir, b_rsp_ir_out, b_ir_in, b_ir_out;
  logic [DR-1:0]  b_cmd_data, b_rsp_data;

  systema_cpu_debug_jtag_host #(.DR_LEN(DR), .IR_LEN(IRW), .TCK_HALF(TH)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_ir_i(cmd_ir), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_ir_out_o(rsp_ir_out),
    .vji_tck_o(vji_tck), .vji_tdi_o(vji_tdi), .vji_tdo_i(vji_tdo),
    .vji_ir_in_o(vji_ir_in), .vji_ir_out_i(vji_ir_out),
    .vji_uir_o(vji_uir), .vji_cdr_o(vji_cdr), .vji_sdr_o(vji_sdr), .vji_udr_o(vji_udr),
    .vji_rti_o(vji_rti)
  );

  systema_cpu_debug_jtag_host #(.DR_LEN(DR), .IR_LEN(IRW), .TCK_HALF(1)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_ir_i(b_cmd_ir), .cmd_data_i(b_cmd_data),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data), .rsp_ir_out_o(b_rsp_ir_out),
    .vji_tck_o(b_tck), .vji_tdi_o(b_tdi), .vji_tdo_i(b_tdo),
    .vji_ir_in_o(b_ir_in), .vji_ir_out_i(b_ir_out),
    .vji_uir_o(b_uir), .vji_cdr_o(b_cdr), .vji_sdr_o(b_sdr), .vji_udr_o(b_udr),
    .vji_rti_o(b_rti)
  );

  // Slave models: capture a pattern at CDR, shift tdi in / tdo out on TCK rise.
  logic [DR-1:0] slv_sr, slv_pat, b_slv_sr, b_slv_pat;
  always @(posedge vji_tck) begin
    if (vji_cdr)      slv_sr <= slv_pat;
    else if (vji_sdr) slv_sr <= {vji_tdi, slv_sr[DR-1:1]};
  end
  assign vji_tdo = slv_sr[0];
  always @(posedge b_tck) begin
    if (b_cdr)      b_slv_sr <= b_slv_pat;
    else if (b_sdr) b_slv_sr <= {b_tdi, b_slv_sr[DR-1:1]};
  end
  assign b_tdo = b_slv_sr[0];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk = nchk + 1;
    if (act !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 idle, 1 scanning (t = clk cycles since accept), 2 response.
  int             m_st = 0;
  int             t = 0;
  int             cyc = 0;
  int             acc_cyc = 0;
  logic [DR-1:0]  m_cmd = '0, m_pat = '0, m_rsp = '0;
  logic [IRW-1:0] m_ir_in = '0, m_irout = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      m_st    <= 0;
      m_rsp   <= '0;
      m_ir_in <= '0;
      m_irout <= '0;
    end else begin
      case (m_st)
        0: if (cmd_valid) begin
          m_st    <= 1;
          t       <= 0;
          m_cmd   <= cmd_data;
          m_ir_in <= cmd_ir;
          m_pat   <= slv_pat;
          acc_cyc <= cyc + 1;
        end
        1: begin
          if (t == TH - 1) m_irout <= vji_ir_out;
          t <= t + 1;
          if (t + 1 == LAT) begin
            m_st  <= 2;
            m_rsp <= m_pat;
          end
        end
        2: if (rsp_ready) m_st <= 0;
        default: m_st <= 0;
      endcase
    end
  end

  bit chk_on = 0;
  always @(negedge clk) begin : compare
    logic [3:0] es;
    logic       etck;
    int         ph;
    if (chk_on) begin
      es   = 4'b0000;
      etck = 1'b0;
      ph   = t / (2 * TH);
      if (m_st == 1) begin
        etck = ((t / TH) % 2) == 1;
        if (ph == 0)           es = 4'b0001;
        else if (ph == 1)      es = 4'b0010;
        else if (ph <= DR + 1) es = 4'b0100;
        else                   es = 4'b1000;
      end
      chk("strobes", {vji_udr, vji_sdr, vji_cdr, vji_uir}, es);
      chk("tck", vji_tck, etck);
      chk("cmd_ready", cmd_ready, m_st == 0);
      chk("rti", vji_rti, m_st == 0);
      chk("rsp_valid", rsp_valid, m_st == 2);
      chk("rsp_data", rsp_data, m_rsp);
      chk("ir_in", vji_ir_in, m_ir_in);
      if (m_st == 2) chk("rsp_ir_out", rsp_ir_out, m_irout);
      if (m_st == 1 && ph >= 2 && ph <= DR + 1) chk("tdi", vji_tdi, m_cmd[ph-2]);
    end
  end

  bit rnd_irout = 0;
  int n_uir, n_cdr, n_sdr, n_udr;

  task automatic tick();
    @(negedge clk);
    if (rnd_irout) vji_ir_out = IRW'($urandom);
  endtask

  task automatic send(input logic [IRW-1:0] ir, input logic [DR-1:0] d, input logic [DR-1:0] pat);
    slv_pat   = pat;
    cmd_ir    = ir;
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int n;
    n = 0; lat = -1;
    n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
    while (!rsp_valid && n < 1000) begin
      n_uir += int'(vji_uir); n_cdr += int'(vji_cdr);
      n_sdr += int'(vji_sdr); n_udr += int'(vji_udr);
      tick();
      n++;
    end
    if (rsp_valid) lat = cyc - acc_cyc;
    else chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat, n;
    bit saw;
    logic [63:0] r;
    logic [DR-1:0] d, p;

    reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_ir = '0; cmd_data = '0;
    vji_ir_out = '0; slv_pat = '0;
    b_cmd_valid = 1'b0; b_rsp_ready = 1'b0; b_cmd_ir = '0; b_cmd_data = '0;
    b_ir_out = '0; b_slv_pat = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rti", vji_rti, 1);
    chk("reset_tck", vji_tck, 0);
    chk("reset_tdi", vji_tdi, 0);
    chk("reset_strobes", {vji_udr, vji_sdr, vji_cdr, vji_uir}, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_ir_out", rsp_ir_out, 0);
    chk("reset_ir_in", vji_ir_in, 0);
    chk_on = 1;

    // Loopback with fixed values, strobe lengths, latency and back-pressure.
    vji_ir_out = 2'b11;
    send(IR_BREAK, 38'h15_1234_5678, 38'h2A_5A5A_5A5A);
    wait_rsp(lat);
    chk("loop_latency", lat, 164);
    chk("loop_n_uir", n_uir, 4);
    chk("loop_n_cdr", n_cdr, 4);
    chk("loop_n_sdr", n_sdr, 152);
    chk("loop_n_udr", n_udr, 4);
    chk("loop_rsp_data", rsp_data, 38'h2A_5A5A_5A5A);
    chk("loop_slave_sr", slv_sr, 38'h15_1234_5678);
    chk("loop_rsp_ir_out", rsp_ir_out, 2'b11);
    chk("loop_ir_in", vji_ir_in, 2'b10);
    repeat (50) tick();
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_data", rsp_data, 38'h2A_5A5A_5A5A);
    chk("bp_cmd_ready", cmd_ready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release_ready", cmd_ready, 1);
    chk("bp_release_valid", rsp_valid, 0);

    // Randomized commands; status input toggles every cycle.
    rnd_irout = 1;
    for (int i = 0; i < 6; i++) begin
      r = {$urandom, $urandom}; d = r[DR-1:0];
      r = {$urandom, $urandom}; p = r[DR-1:0];
      send(IRW'($urandom), d, p);
      wait_rsp(lat);
      chk("rand_latency", lat, LAT);
      chk("rand_slave_sr", slv_sr, d);
      repeat ($urandom_range(0, 5)) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    rnd_irout = 0;

    // Back-to-back with cmd_valid held high.
    rsp_ready = 1'b1;
    slv_pat   = 38'h0F_0F0F_0F0F;
    cmd_ir    = IR_TRACE;
    cmd_data  = 38'h3F_FFFF_0001;
    cmd_valid = 1'b1;
    tick();
    cmd_data  = 38'h00_ABCD_EF12;
    wait_rsp(lat);
    chk("b2b_first_data", rsp_data, 38'h0F_0F0F_0F0F);
    tick();
    chk("b2b_hs_valid", rsp_valid, 0);
    chk("b2b_hs_ready", cmd_ready, 1);
    tick();
    chk("b2b_accept_uir", vji_uir, 1);
    chk("b2b_accept_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("b2b_second_data", rsp_data, 38'h0F_0F0F_0F0F);
    chk("b2b_second_slave", slv_sr, 38'h00_ABCD_EF12);
    tick();
    rsp_ready = 1'b0;

    // Reset during bit 20 of SHIFT.
    send(IR_OCIMEM, 38'h2B_DEAD_BEEF, 38'h11_2233_4455);
    n = 0;
    while (t != 89 && n < 500) begin tick(); n++; end
    chk("rst_reach_bit20", t, 89);
    chk("rst_in_sdr", vji_sdr, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst_strobes", {vji_udr, vji_sdr, vji_cdr, vji_uir}, 0);
    chk("rst_tck", vji_tck, 0);
    chk("rst_rti", vji_rti, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
    saw = 0;
    rsp_ready = 1'b1;
    repeat (200) begin tick(); if (rsp_valid) saw = 1; end
    rsp_ready = 1'b0;
    chk("rst_no_rsp", saw, 0);

    // TCK_HALF=1 instance: loopback latency and data.
    b_slv_pat   = 38'h2A_5A5A_5A5A;
    b_ir_out    = 2'b01;
    b_cmd_ir    = IR_BREAK;
    b_cmd_data  = 38'h15_1234_5678;
    b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    acc_cyc = cyc;
    n = 0;
    while (!b_rsp_valid && n < 500) begin tick(); n++; end
    chk("th1_latency", cyc - acc_cyc, 82);
    chk("th1_rsp_data", b_rsp_data, 38'h2A_5A5A_5A5A);
    chk("th1_slave_sr", b_slv_sr, 38'h15_1234_5678);
    chk("th1_rsp_ir_out", b_rsp_ir_out, 2'b01);
    b_rsp_ready = 1'b1;
    tick();
    chk("th1_release", b_cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/systema_cpu_debug_jtag_host.md
Name: systema_cpu_debug_jtag_host

Overview:
- Initiator (host) end of the CPU debug slave's virtual-JTAG interface.
- Drives the vji_* strobes and scan clock that the debug slave's TCK domain consumes: IR load, DR capture, DR shift, DR update.
- Converts a parallel command (2-bit IR, 38-bit DR) into one full scan sequence and returns the 38 bits shifted out.
- Used in simulation benches and as an on-chip debug bridge in place of the hard JTAG hub.

Parameters:
- DR_LEN, 38, scan-chain length in bits; equals the debug slave's sr/jdo width.
- IR_LEN, 2, virtual IR width.
- TCK_HALF, 2, clk cycles per TCK half-period; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic is on this edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  host idle and able to accept a command.
- cmd_ir  in  IR_LEN  IR value for this scan.
- cmd_data  in  DR_LEN  DR value to shift in, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DR_LEN  bits captured from vji_tdo.
- rsp_ir_out  out  IR_LEN  vji_ir_out sampled during the UIR phase.
- vji_tck  out  1  generated scan clock.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_LEN  virtual IR value.
- vji_ir_out  in  IR_LEN  status returned by the slave.
- vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual-state strobes.
- vji_rti  out  1  run-test-idle indication.

Behaviour:
- Reset (reset_n=0 at a clk edge) forces every output to its reset value:
  - vji_tck=0, vji_tdi=0, vji_ir_in=0, all four strobes=0, vji_rti=1.
  - cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_ir_out=0.
  - FSM=IDLE, all counters=0.
- Reset mid-scan aborts the scan immediately. No UDR is issued and no response is produced.
- TCK generation:
  - A half-period counter counts 0..TCK_HALF-1 and toggles vji_tck on wrap.
  - vji_tck is held at 0 in IDLE and RESP.
  - One "TCK cycle" is 2*TCK_HALF clk cycles: low half first, then high half.
- FSM states: IDLE, UIR, CDR, SHIFT, UDR, RESP.
- IDLE:
  - cmd_ready=1 and vji_rti=1.
  - On cmd_valid&&cmd_ready: latch cmd_ir into vji_ir_in, load the shift register with cmd_data, set cmd_ready=0 and vji_rti=0, go to UIR.
- UIR: vji_uir=1 for exactly one TCK cycle. vji_ir_out is sampled into rsp_ir_out at the TCK rising edge. Then go to CDR.
- CDR: vji_cdr=1 for one TCK cycle. Then go to SHIFT.
- SHIFT:
  - vji_sdr=1 for exactly DR_LEN TCK cycles; a bit counter runs 0..DR_LEN-1.
  - vji_tdi = shift register bit 0, stable across the whole TCK cycle. It changes only at a TCK falling edge, i.e. a clk cycle where tck goes 1->0.
  - At each TCK rising edge, vji_tdo is sampled: shift register <= {tdo, sr[DR_LEN-1:1]}.
  - After DR_LEN cycles the first bit out of tdo sits at rsp_data[0].
- UDR: vji_udr=1 for one TCK cycle. Then go to RESP, with rsp_data=shift register and rsp_valid=1.
- RESP:
  - vji_ir_in retains the last IR value.
  - rsp_valid and rsp_data stay stable until rsp_ready=1. At that point rsp_valid=0 and the FSM returns to IDLE.
  - If cmd_valid=1 is held during this state, the command is not accepted until the cycle after return to IDLE.
- Strobes are mutually exclusive (one-hot or all zero) at every cycle. vji_rti=1 only in IDLE.
- Latency, from the cmd accept edge to rsp_valid=1: (DR_LEN+3)*2*TCK_HALF clk cycles. With defaults this is 164.
- cmd_data/cmd_ir changes while busy are ignored. No queueing; single outstanding command.

Decomposition:
- Package systema_cpu_debug_jtag_pkg holds:
  - the FSM state enum;
  - default DR_LEN/IR_LEN;
  - IR codes as named constants: 2'b00 OCIMEM, 2'b01 TRACE, 2'b10 BREAK, 2'b11 TRACEMEM.
- One sub-module, systema_cpu_debug_jtag_tckgen:
  - contains the half-period counter and the tck register;
  - outputs one-clk pulses tck_rise/tck_fall plus an enable input.
- The FSM and shifter stay in the top module.

Test Plan:
- Loopback (tdo driven from a 38-bit bench model of the slave's sr, loaded with 38'h2A_5A5A_5A5A at CDR), cmd_ir=2'b10, cmd_data=38'h15_1234_5678 -> rsp_data=38'h2A_5A5A_5A5A; the bench model holds 38'h15_1234_5678 at UDR.
- Strobe sequencing with TCK_HALF=2 -> exactly 4 clk cycles of UIR, then 4 of CDR, then 152 of SDR, then 4 of UDR; never two strobes high together; vji_rti=0 throughout; rsp_valid at clk 164 after accept.
- Back-pressure, rsp_ready=0 for 50 cycles -> rsp_valid and rsp_data held stable, cmd_ready=0; rsp_ready=1 -> IDLE next cycle, cmd_ready=1.
- Reset asserted at bit 20 of SHIFT -> next clk: all strobes 0, vji_tck=0, vji_rti=1, cmd_ready=1; no rsp_valid ever appears for that command.
- vji_ir_out=2'b11 during UIR -> rsp_ir_out=2'b11; TCK_HALF=1 run of the loopback case -> latency 82 cycles, same data.
- Two back-to-back commands with cmd_valid held high -> second accepted exactly 1 cycle after the first response handshake; tdi is stable between tck falling edges.
